// File: rtl/axi_axil_adapter_wr.sv
// axi_axil_adapter_wr: splits AXI4 write bursts into single-beat AXI-lite writes and merges the beat responses.
module axi_axil_adapter_wr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready
);
  localparam int SW = $clog2(STRB_WIDTH);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic s_awready_q, s_awready_d, s_wready_q, s_wready_d, s_bvalid_q, s_bvalid_d;
  logic m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d, m_bready_q, m_bready_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0] id_q, id_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, step;
  logic [2:0] size_q, size_d, prot_q, prot_d;
  logic fixed_q, fixed_d;
  logic [1:0] resp_acc_q, resp_acc_d, bresp_q, bresp_d, resp_m;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;
  assign step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
  // first error response seen in the burst wins
  assign resp_m = (resp_acc_q == 2'b00) ? m_axil_bresp : resp_acc_q;
  always_comb begin
    state_d = state_q;
    beat_cnt_d = beat_cnt_q;
    id_d = id_q;
    bid_d = bid_q;
    addr_d = addr_q;
    size_d = size_q;
    prot_d = prot_q;
    fixed_d = fixed_q;
    resp_acc_d = resp_acc_q;
    bresp_d = bresp_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    m_awvalid_d = m_awvalid_q && !m_axil_awready;
    m_wvalid_d = m_wvalid_q && !m_axil_wready;
    s_bvalid_d = s_bvalid_q && !s_axi_bready;
    case (state_q)
      IDLE: if (s_awready_q && s_axi_awvalid) begin
        id_d = s_axi_awid;
        addr_d = s_axi_awaddr;
        beat_cnt_d = s_axi_awlen;
        size_d = (s_axi_awsize > 3'(SW)) ? 3'(SW) : s_axi_awsize;
        fixed_d = s_axi_awburst == 2'b00;
        prot_d = s_axi_awprot;
        resp_acc_d = 2'b00;
        m_awvalid_d = 1'b1;
        state_d = DATA;
      end
      DATA: if (s_wready_q && s_axi_wvalid) begin
        wdata_d = s_axi_wdata;
        wstrb_d = s_axi_wstrb;
        m_wvalid_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (m_bready_q && m_axil_bvalid) begin
        resp_acc_d = resp_m;
        if (beat_cnt_q == 8'd0) begin
          s_bvalid_d = 1'b1;
          bid_d = id_q;
          bresp_d = resp_m;
          state_d = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q - 8'd1;
          addr_d = fixed_q ? addr_q : (addr_q & ~(step - 1'b1)) + step;
          m_awvalid_d = 1'b1;
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
    s_awready_d = (state_d == IDLE) && !m_awvalid_d;
    s_wready_d = (state_d == DATA) && !m_wvalid_d;
    m_bready_d = (state_d == RESP) && !s_bvalid_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_awready_q <= 1'b0;
      s_wready_q <= 1'b0;
      s_bvalid_q <= 1'b0;
      m_awvalid_q <= 1'b0;
      m_wvalid_q <= 1'b0;
      m_bready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_awready_q <= s_awready_d;
      s_wready_q <= s_wready_d;
      s_bvalid_q <= s_bvalid_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q <= m_wvalid_d;
      m_bready_q <= m_bready_d;
    end
  end
  always_ff @(posedge clk) begin
    beat_cnt_q <= beat_cnt_d;
    id_q <= id_d;
    bid_q <= bid_d;
    addr_q <= addr_d;
    size_q <= size_d;
    prot_q <= prot_d;
    fixed_q <= fixed_d;
    resp_acc_q <= resp_acc_d;
    bresp_q <= bresp_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end
  assign s_axi_awready = s_awready_q;
  assign s_axi_wready = s_wready_q;
  assign s_axi_bvalid = s_bvalid_q;
  assign s_axi_bid = bid_q;
  assign s_axi_bresp = bresp_q;
  assign m_axil_awaddr = addr_q;
  assign m_axil_awprot = prot_q;
  assign m_axil_awvalid = m_awvalid_q;
  assign m_axil_wdata = wdata_q;
  assign m_axil_wstrb = wstrb_q;
  assign m_axil_wvalid = m_wvalid_q;
  assign m_axil_bready = m_bready_q;
endmodule

// File: tb/tb_axi_axil_adapter_wr.sv
// tb_axi_axil_adapter_wr: directed bursts against a small AXI-lite slave model with hand-computed expectations.
module tb_axi_axil_adapter_wr;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_axi_awid = '0, s_axi_awlen = '0, s_axi_bid;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, m_axil_awaddr, m_axil_wdata;
  logic [2:0] s_axi_awsize = '0, s_axi_awprot = '0, m_axil_awprot;
  logic [1:0] s_axi_awburst = 2'b01, s_axi_bresp, m_axil_bresp = '0;
  logic [3:0] s_axi_wstrb = '0, m_axil_wstrb;
  logic s_axi_awvalid = 0, s_axi_awready, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready = 0;
  logic m_axil_awvalid, m_axil_awready = 0, m_axil_wvalid, m_axil_wready = 0;
  logic m_axil_bvalid = 0, m_axil_bready;
  int n_chk = 0, n_fail = 0, b_count = 0;
  logic stall = 0, have_aw = 0, have_w = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
  logic [31:0] aw_log[$], wd_log[$];
  logic [3:0] ws_log[$];
  logic [1:0] resp_q[$];
  axi_axil_adapter_wr dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (s_axi_bvalid && s_axi_bready) b_count <= b_count + 1;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // slave model: decides drives at each negedge, then logs handshakes that will fire on the next posedge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
      have_aw = 0; have_w = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
    end else begin
      if (b_fire) m_axil_bvalid = 0;
      if (!m_axil_bvalid && have_aw && have_w && (!stall || $urandom_range(0, 1) == 1)) begin
        m_axil_bvalid = 1;
        m_axil_bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
        have_aw = 0; have_w = 0;
      end
      m_axil_awready = !stall || $urandom_range(0, 1) == 1;
      m_axil_wready = !stall || $urandom_range(0, 1) == 1;
      aw_fire = m_axil_awvalid && m_axil_awready;
      w_fire = m_axil_wvalid && m_axil_wready;
      b_fire = m_axil_bvalid && m_axil_bready;
      if (aw_fire) begin aw_log.push_back(m_axil_awaddr); have_aw = 1; end
      if (w_fire) begin wd_log.push_back(m_axil_wdata); ws_log.push_back(m_axil_wstrb); have_w = 1; end
    end
  end
  task automatic send_aw(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bt);
    int n = 0;
    s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = bt;
    s_axi_awvalid = 1;
    while (!s_axi_awready && n < 300) begin @(negedge clk); n++; end
    chk("aw_timeout", n < 300, 1);
    @(negedge clk);
    s_axi_awvalid = 0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    while (!s_axi_wready && n < 300) begin @(negedge clk); n++; end
    chk("w_timeout", n < 300, 1);
    @(negedge clk);
    s_axi_wvalid = 0;
  endtask
  task automatic wait_b(input logic [7:0] id, input logic [1:0] resp);
    int n = 0;
    s_axi_bready = 1;
    while (!s_axi_bvalid && n < 300) begin @(negedge clk); n++; end
    chk("b_timeout", n < 300, 1);
    chk("bid", s_axi_bid, id);
    chk("bresp", s_axi_bresp, resp);
    @(negedge clk);
    s_axi_bready = 0;
  endtask
  task automatic clear_logs();
    aw_log.delete(); wd_log.delete(); ws_log.delete();
  endtask
  initial begin
    logic [31:0] exp_a[4];
    logic hold_ok;
    int n, b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 6'b0);
    rst = 0;
    @(negedge clk);
    chk("idle_awready", s_axi_awready, 1);
    // 1: single beat
    s_axi_awprot = 3'b101;
    send_aw(8'd5, 32'h100, 8'd0, 3'd2, 2'b01);
    send_w(32'hDEADBEEF, 4'hF);
    wait_b(8'd5, 2'b00);
    chk("t1_n", aw_log.size(), 1);
    chk("t1_addr", aw_log[0], 32'h100);
    chk("t1_data", wd_log[0], 32'hDEADBEEF);
    chk("t1_strb", ws_log[0], 4'hF);
    chk("t1_prot", m_axil_awprot, 3'b101);
    chk("t1_bcnt", b_count, 1);
    // 2: INCR with unaligned start
    clear_logs();
    send_aw(8'd6, 32'h1002, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF);
    wait_b(8'd6, 2'b00);
    exp_a = '{32'h1002, 32'h1004, 32'h1008, 32'h100C};
    chk("t2_n", aw_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", aw_log[i], exp_a[i]);
      chk("t2_data", wd_log[i], 32'hA0 + i);
    end
    chk("t2_bcnt", b_count, 2);
    // 3: FIXED
    clear_logs();
    send_aw(8'd3, 32'h20, 8'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) send_w(32'hB0 + i, 4'b0001 << i);
    wait_b(8'd3, 2'b00);
    chk("t3_n", aw_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_addr", aw_log[i], 32'h20);
      chk("t3_strb", ws_log[i], 4'b0001 << i);
    end
    // 4: first error is sticky
    resp_q = '{2'b00, 2'b10, 2'b11, 2'b00};
    send_aw(8'd4, 32'h40, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'hC0 + i, 4'hF);
    wait_b(8'd4, 2'b10);
    chk("t4_bcnt", b_count, 4);
    // 5: first B held while a second burst starts
    clear_logs();
    send_aw(8'd7, 32'h300, 8'd0, 3'd2, 2'b01);
    send_w(32'h77, 4'hF);
    n = 0;
    while (!s_axi_bvalid && n < 300) begin @(negedge clk); n++; end
    chk("t5_b1_timeout", n < 300, 1);
    send_aw(8'd9, 32'h400, 8'd1, 3'd2, 2'b01);
    send_w(32'h90, 4'hF);
    hold_ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!s_axi_bvalid || s_axi_bid !== 8'd7 || m_axil_bready) hold_ok = 0;
    end
    chk("t5_hold", hold_ok, 1);
    fork
      wait_b(8'd7, 2'b00);
      send_w(32'h91, 4'hF);
    join
    wait_b(8'd9, 2'b00);
    chk("t5_n", aw_log.size(), 3);
    chk("t5_a1", aw_log[1], 32'h400);
    chk("t5_a2", aw_log[2], 32'h404);
    chk("t5_d2", wd_log[2], 32'h91);
    chk("t5_bcnt", b_count, 6);
    // 6: reset mid-burst under random slave stalls
    stall = 1;
    send_aw(8'h11, 32'h500, 8'd3, 3'd2, 2'b01);
    send_w(32'hE0, 4'hF);
    send_w(32'hE1, 4'hF);
    b0 = b_count;
    #2 rst = 1;
    @(negedge clk);
    chk("t6_rst_outs", {s_axi_awready, s_axi_wready, s_axi_bvalid, m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 6'b0);
    #2 rst = 0;
    repeat (3) @(negedge clk);
    resp_q.delete();
    clear_logs();
    chk("t6_no_b", b_count, b0);
    send_aw(8'h12, 32'h600, 8'd1, 3'd2, 2'b01);
    send_w(32'hF0, 4'h3);
    send_w(32'hF1, 4'hC);
    wait_b(8'h12, 2'b00);
    chk("t6_n", aw_log.size(), 2);
    chk("t6_a0", aw_log[0], 32'h600);
    chk("t6_a1", aw_log[1], 32'h604);
    chk("t6_d1", wd_log[1], 32'hF1);
    chk("t6_s1", ws_log[1], 4'hC);
    chk("t6_bcnt", b_count, b0 + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
